// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-interface types: data word and RAM status encoding.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction fetch and data access paths.
// A grant is held by one requester until it completes (ACCESS), faults
// (ERROR or wait timeout) or drops its request; one idle cycle always separates
// grants. Data requests win in IDLE unless they have already starved a waiting
// instruction fetch STARVE_LIMIT times in a row.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      ihit,
    output logic      dhit,
    output word_t     iload,
    output word_t     dload,
    output logic      memerr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [2:0] STARVE_C  = 3'(STARVE_LIMIT);

    state_t      state_r;
    logic [7:0]  wait_cnt_r;
    logic [2:0]  starve_cnt_r;

    logic        dreq_s;
    logic        owner_req_s;
    logic        access_s;
    logic        fault_s;
    logic        end_s;

    // Decode the current owner's request and how its grant ends this cycle.
    always_comb begin
        dreq_s      = dREN | dWEN;
        owner_req_s = 1'b0;
        case (state_r)
            IGRANT:  owner_req_s = iREN;
            DGRANT:  owner_req_s = dreq_s;
            default: owner_req_s = 1'b0;
        endcase
        access_s = owner_req_s && (ramstate == ACCESS);
        // A dropped request ends quietly; only a live request can fault.
        fault_s  = owner_req_s && !access_s &&
                   ((ramstate == ERROR) || (wait_cnt_r == TIMEOUT_C));
        end_s    = !owner_req_s || access_s || fault_s;
    end

    // Drive the RAM port and completion pulses from the owner; reset silences all.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        memerr   = 1'b0;
        iload    = ramload;
        dload    = ramload;
        if (!RST) begin
            memerr = fault_s;
            case (state_r)
                IGRANT: begin
                    ramREN  = iREN;
                    ramaddr = iaddr;
                    ihit    = access_s;
                end
                DGRANT: begin
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    dhit     = access_s;
                end
                default: begin
                    ramREN = 1'b0;
                end
            endcase
        end else begin
            memerr = 1'b0;
        end
    end

    // Grant FSM with per-grant wait counter and instruction-starvation counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            wait_cnt_r   <= 8'd0;
            starve_cnt_r <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    wait_cnt_r <= 8'd0;
                    if (dreq_s && (!iREN || (starve_cnt_r < STARVE_C))) begin
                        state_r <= DGRANT;
                        if (iREN) begin
                            if (starve_cnt_r < STARVE_C) begin
                                starve_cnt_r <= starve_cnt_r + 3'd1;
                            end else begin
                                starve_cnt_r <= STARVE_C;
                            end
                        end else begin
                            starve_cnt_r <= 3'd0;
                        end
                    end else if (iREN) begin
                        state_r      <= IGRANT;
                        starve_cnt_r <= 3'd0;
                    end else begin
                        state_r      <= IDLE;
                        starve_cnt_r <= 3'd0;
                    end
                end
                IGRANT, DGRANT: begin
                    wait_cnt_r <= wait_cnt_r + 8'd1;
                    if (end_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    wait_cnt_r <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;
    logic      memerr;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the RAM, how long it has waited, data wins in a row.
    int   m_owner  = 0;   // 0 none, 1 instruction, 2 data
    int   m_wait   = 0;
    int   m_starve = 0;
    logic last_ihit_m = 1'b0;
    logic last_dhit_m = 1'b0;
    logic e_ren, e_wen, e_ihit, e_dhit, e_err, e_req;
    word_t e_addr, e_store;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload), .memerr(memerr)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compare every cycle against the model, then advance the model across the edge.
    always @(negedge CLK) begin
        e_ren = 1'b0; e_wen = 1'b0; e_ihit = 1'b0; e_dhit = 1'b0; e_err = 1'b0; e_req = 1'b0;
        e_addr = 32'd0; e_store = 32'd0;
        if (!RST && m_owner == 1) begin
            e_req  = iREN;
            e_ren  = iREN;
            e_addr = iaddr;
        end else if (!RST && m_owner == 2) begin
            e_req   = dREN || dWEN;
            e_ren   = dREN;
            e_wen   = dWEN;
            e_addr  = daddr;
            e_store = dstore;
        end else begin
            e_req = 1'b0;
        end
        if (e_req && ramstate == ACCESS) begin
            e_ihit = (m_owner == 1);
            e_dhit = (m_owner == 2);
        end
        e_err = e_req && (ramstate == ERROR || (ramstate != ACCESS && m_wait == TIMEOUT));

        check_val("ctrl", {27'd0, ramREN, ramWEN, ihit, dhit, memerr},
                          {27'd0, e_ren, e_wen, e_ihit, e_dhit, e_err});
        check_val("ramaddr", ramaddr, e_addr);
        check_val("ramstore", ramstore, e_store);
        check_val("iload", iload, ramload);
        check_val("dload", dload, ramload);
        last_ihit_m = e_ihit;
        last_dhit_m = e_dhit;

        if (RST) begin
            m_owner = 0; m_wait = 0; m_starve = 0;
        end else if (m_owner == 0) begin
            m_wait = 0;
            if ((dREN || dWEN) && (!iREN || m_starve < STARVE_LIMIT)) begin
                m_owner  = 2;
                m_starve = iREN ? ((m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1) : 0;
            end else if (iREN) begin
                m_owner  = 1;
                m_starve = 0;
            end else begin
                m_starve = 0;
            end
        end else begin
            if (!e_req || e_ihit || e_dhit || e_err) m_owner = 0;
            m_wait++;
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        string exp_s;
        byte   obs_c;
        int    found;
        int    dh;

        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
        ramload = 32'h0BAD_F00D; ramstate = FREE;
        tick(); tick(); tick();
        @(negedge CLK);
        check_val("rst_ren", ramREN, 1'b0);
        check_val("rst_iload", iload, 32'h0BAD_F00D);
        RST = 1'b0;
        tick();

        // Instruction read completing after two BUSY cycles.
        iREN = 1'b1; iaddr = 32'h100; ramstate = BUSY;
        @(negedge CLK); check_val("a_idle_ren", ramREN, 1'b0); tick();
        @(negedge CLK); check_val("a_ren1", ramREN, 1'b1); check_val("a_addr1", ramaddr, 32'h100); tick();
        @(negedge CLK); check_val("a_ren2", ramREN, 1'b1); check_val("a_ihit2", ihit, 1'b0); tick();
        ramstate = ACCESS; ramload = 32'h1234_5678;
        @(negedge CLK);
        check_val("a_ren3", ramREN, 1'b1);
        check_val("a_ihit3", ihit, 1'b1);
        check_val("a_iload3", iload, 32'h1234_5678);
        tick();
        iREN = 1'b0; ramstate = FREE;
        @(negedge CLK); check_val("a_after", ramREN, 1'b0); tick();

        // Both held, RAM always ready: data wins STARVE_LIMIT times, then instruction.
        iREN = 1'b1; iaddr = 32'h300; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
        ramstate = ACCESS;
        exp_s = "-D-D-D-D-I-D";
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            obs_c = ramWEN ? "D" : (ramREN ? "I" : "-");
            check_val("b_grant_seq", obs_c, exp_s[k]);
            tick();
        end
        iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        tick(); tick();

        // Data read with RAM stuck BUSY: timeout after the wait counter reaches 255.
        dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        found = -1; dh = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (dhit) dh++;
            if (memerr) begin
                found = i;
                break;
            end
            tick();
        end
        check_val("c_memerr_cycle", found, 32'd256);
        tick();
        @(negedge CLK);
        check_val("c_idle_ren", ramREN, 1'b0);
        check_val("c_no_dhit", dh, 32'd0);
        check_val("c_memerr_pulse", memerr, 1'b0);
        dREN = 1'b0; ramstate = FREE;
        tick(); tick();

        // RAM ERROR during an instruction grant.
        iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
        tick();
        @(negedge CLK); check_val("d_ren", ramREN, 1'b1); tick();
        ramstate = ERROR;
        @(negedge CLK); check_val("d_memerr", memerr, 1'b1); check_val("d_ihit", ihit, 1'b0); tick();
        iREN = 1'b0; ramstate = FREE;
        @(negedge CLK); check_val("d_memerr_end", memerr, 1'b0); check_val("d_ren_end", ramREN, 1'b0); tick();

        // Data request dropped one cycle into its grant while a fetch waits.
        iREN = 1'b1; iaddr = 32'h600; dREN = 1'b1; daddr = 32'h700; ramstate = BUSY;
        @(negedge CLK); check_val("e_idle", ramREN, 1'b0); tick();
        @(negedge CLK); check_val("e_daddr", ramaddr, 32'h700); tick();
        dREN = 1'b0;
        @(negedge CLK); check_val("e_drop_dhit", dhit, 1'b0); check_val("e_drop_err", memerr, 1'b0); tick();
        @(negedge CLK); check_val("e_idle2", ramREN, 1'b0); tick();
        ramstate = ACCESS;
        @(negedge CLK); check_val("e_iaddr", ramaddr, 32'h600); check_val("e_ihit", ihit, 1'b1); tick();
        iREN = 1'b0; ramstate = FREE;
        tick();

        // Reset asserted in the middle of a data grant.
        iREN = 1'b1; iaddr = 32'h800; dWEN = 1'b1; daddr = 32'h900; dstore = 32'hCAFE_0001;
        ramstate = BUSY;
        tick();
        @(negedge CLK); check_val("f_wen", ramWEN, 1'b1); tick();
        RST = 1'b1;
        @(negedge CLK); check_val("f_rst_wen", ramWEN, 1'b0); check_val("f_rst_dhit", dhit, 1'b0); tick();
        RST = 1'b0;
        @(negedge CLK);
        check_val("f_post_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        check_val("f_starve", dut.starve_cnt_r, 32'd0);
        tick();
        iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        tick(); tick();

        // Randomized traffic honouring the hold-until-hit request protocol.
        for (int c = 0; c < 3000; c++) begin
            if (!iREN) begin
                if ($urandom_range(0, 2) == 0) begin
                    iREN  = 1'b1;
                    iaddr = $urandom;
                end
            end else if (last_ihit_m || $urandom_range(0, 31) == 0) begin
                iREN = 1'b0;
            end
            if (!(dREN || dWEN)) begin
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 1) dREN = 1'b1;
                    else dWEN = 1'b1;
                    daddr  = $urandom;
                    dstore = $urandom;
                end
            end else if (last_dhit_m || $urandom_range(0, 31) == 0) begin
                dREN = 1'b0;
                dWEN = 1'b0;
            end
            case ($urandom_range(0, 9))
                0:          ramstate = FREE;
                1:          ramstate = ERROR;
                2, 3, 4, 5: ramstate = BUSY;
                default:    ramstate = ACCESS;
            endcase
            ramload = $urandom;
            RST = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
